// File: rtl/rv_bfm_pkg.sv
// Shared defaults and helpers for the ready/valid data-out BFM.
// Exports DEF_DATA_WIDTH, DEF_DEPTH and lvl_w() for level port sizing.
package rv_bfm_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rv_bfm_fifo.sv
// Synchronous FIFO: push/pop, full/empty, level; sync active-high reset.
// Ports: clock, reset, push, push_data, pop, rd_data, level, full, empty.
module rv_bfm_fifo
  import rv_bfm_pkg::*;
#(
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = lvl_w(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (1'b1)
      (do_push && !do_pop): level_d = level_q + LW'(1);
      (do_pop && !do_push): level_d = level_q - LW'(1);
      default:              level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; pointers define what is live.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rv_data_out_bfm.sv
// Ready/valid source BFM: host queue feeding a sink, plus transfer monitor.
// Ports: clock, reset, data/valid/ready, push_*, level, xfer_*.
module rv_data_out_bfm
  import rv_bfm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      data_valid,
  input  logic                      data_ready,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      push_valid,
  output logic                      push_ready,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      xfer_valid,
  output logic [DATA_WIDTH-1:0]     xfer_data,
  output logic [31:0]               xfer_count
);

  localparam int LW = lvl_w(DEPTH);

  logic [DATA_WIDTH-1:0] fifo_data;
  logic [LW-1:0]         fifo_level;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  xfer;
  logic                  push;

  logic                  xfer_valid_q, xfer_valid_d;
  logic [DATA_WIDTH-1:0] xfer_data_q, xfer_data_d;
  logic [31:0]           xfer_count_q, xfer_count_d;

  // Outputs derive from registered FIFO state; reset only masks them.
  assign data_valid = !fifo_empty && !reset;
  assign data       = data_valid ? fifo_data : '0;
  assign level      = reset ? '0 : fifo_level;
  assign push_ready = !fifo_full && !reset;
  assign xfer       = data_valid && data_ready;
  assign push       = push_valid && push_ready;

  rv_bfm_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (xfer),
    .rd_data   (fifo_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    xfer_valid_d = xfer;
    xfer_data_d  = xfer_data_q;
    xfer_count_d = xfer_count_q;
    if (xfer) begin
      xfer_data_d  = data;
      xfer_count_d = xfer_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xfer_valid_q <= 1'b0;
      xfer_data_q  <= '0;
      xfer_count_q <= '0;
    end else begin
      xfer_valid_q <= xfer_valid_d;
      xfer_data_q  <= xfer_data_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_valid = xfer_valid_q && !reset;
  assign xfer_data  = reset ? '0 : xfer_data_q;
  assign xfer_count = reset ? '0 : xfer_count_q;

endmodule

// File: tb/tb_rv_data_out_bfm.sv
// Randomized bench for rv_data_out_bfm against a queue-based model.
// Compares every cycle at negedge; directed scenarios pin the model.
module tb_rv_data_out_bfm;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          data_ready;
  logic [DW-1:0] push_data;
  logic          push_valid;
  logic          push_ready;
  logic [LW-1:0] level;
  logic          xfer_valid;
  logic [DW-1:0] xfer_data;
  logic [31:0]   xfer_count;

  int checks;
  int failures;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] obs[$];
  logic          mxv;
  logic [DW-1:0] mxd;
  logic [31:0]   mcnt;
  bit            saw_dead;

  rv_data_out_bfm #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .push_data  (push_data),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .level      (level),
    .xfer_valid (xfer_valid),
    .xfer_data  (xfer_data),
    .xfer_count (xfer_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: a word queue plus transfer bookkeeping.
  always @(posedge clock) begin
    bit pu;
    bit po;
    if (reset) begin
      mq.delete();
      mxv  = 1'b0;
      mxd  = '0;
      mcnt = '0;
    end else begin
      pu  = push_valid && (mq.size() < DEPTH);
      po  = data_ready && (mq.size() != 0);
      mxv = po;
      if (po) begin
        mxd  = mq.pop_front();
        mcnt = mcnt + 32'd1;
      end
      if (pu) mq.push_back(push_data);
    end
  end

  always @(negedge clock) begin
    chk("data_valid", 64'(data_valid),
        64'(!reset && mq.size() != 0));
    chk("push_ready", 64'(push_ready),
        64'(!reset && mq.size() < DEPTH));
    chk("level", 64'(level), reset ? 64'd0 : 64'(mq.size()));
    if (reset) chk("data_rst", 64'(data), 64'd0);
    else if (mq.size() != 0) chk("data", 64'(data), 64'(mq[0]));
    chk("xfer_valid", 64'(xfer_valid), reset ? 64'd0 : 64'(mxv));
    chk("xfer_data", 64'(xfer_data), reset ? 64'd0 : 64'(mxd));
    chk("xfer_count", 64'(xfer_count), reset ? 64'd0 : 64'(mcnt));
    if (xfer_valid) begin
      obs.push_back(xfer_data);
      if (xfer_data == 32'hDEADBEEF) saw_dead = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  initial begin
    int base;
    int d;
    checks     = 0;
    failures   = 0;
    saw_dead   = 1'b0;
    mxv        = 1'b0;
    mxd        = '0;
    mcnt       = '0;
    reset      = 1'b1;
    push_valid = 1'b1;
    push_data  = 32'hAAAA5555;
    data_ready = 1'b0;

    // Reset held 11 cycles with push_valid high.
    repeat (11) tick();
    chk("rst_push_ready", 64'(push_ready), 64'd0);

    // First push accepted right after release.
    reset     = 1'b0;
    push_data = 32'd1;
    #1;
    chk("rel_push_ready", 64'(push_ready), 64'd1);
    chk("rel_level", 64'(level), 64'd0);
    tick();
    chk("first_push_level", 64'(level), 64'd1);
    for (int i = 2; i <= 5; i++) begin
      push_data = 32'(i);
      tick();
    end
    push_valid = 1'b0;
    chk("five_level", 64'(level), 64'd5);
    chk("five_data", 64'(data), 64'd1);
    chk("five_valid", 64'(data_valid), 64'd1);
    repeat (3) tick();
    chk("hold_data", 64'(data), 64'd1);

    // Drain with random sink delays.
    base = obs.size();
    for (int i = 0; i < 5; i++) begin
      d = int'($urandom_range(0, 31));
      data_ready = 1'b0;
      repeat (d) tick();
      data_ready = 1'b1;
      tick();
    end
    data_ready = 1'b0;
    tick();
    chk("drain_n", 64'(obs.size() - base), 64'd5);
    for (int i = 0; i < 5; i++)
      if (base + i < obs.size())
        chk("drain_seq", 64'(obs[base + i]), 64'(i + 1));
    chk("drain_count", 64'(xfer_count), 64'd5);

    // Fill to full, then an extra push is dropped.
    push_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_data = 32'h100 + 32'(i);
      tick();
    end
    chk("full_level", 64'(level), 64'd16);
    chk("full_ready", 64'(push_ready), 64'd0);
    push_data = 32'hDEADBEEF;
    repeat (3) tick();
    chk("full_level2", 64'(level), 64'd16);
    push_valid = 1'b0;
    data_ready = 1'b1;
    base = obs.size();
    repeat (16) tick();
    data_ready = 1'b0;
    tick();
    chk("full_drain_n", 64'(obs.size() - base), 64'd16);
    chk("full_count", 64'(xfer_count), 64'd21);
    chk("full_last", 64'(obs[obs.size() - 1]), 64'h10F);
    chk("dead_seen", 64'(saw_dead), 64'd0);
    chk("full_empty", 64'(level), 64'd0);

    // Streaming: push and transfer every cycle.
    push_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_data = 32'h200 + 32'(i);
      tick();
    end
    base = obs.size();
    data_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      push_data = 32'h300 + 32'(i);
      tick();
    end
    chk("stream_level", 64'(level), 64'd4);
    chk("stream_pulses", 64'(obs.size() - base), 64'd100);
    chk("stream_first", 64'(obs[base]), 64'h200);
    chk("stream_5th", 64'(obs[base + 4]), 64'h300);
    push_valid = 1'b0;
    repeat (4) tick();
    data_ready = 1'b0;

    // Reset mid-operation with seven queued words.
    push_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push_data = 32'h400 + 32'(i);
      tick();
    end
    push_valid = 1'b0;
    chk("seven_level", 64'(level), 64'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_valid", 64'(data_valid), 64'd0);
    chk("mid_rst_count", 64'(xfer_count), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      push_valid = $urandom_range(0, 99) < 60;
      data_ready = $urandom_range(0, 99) < 50;
      push_data  = $urandom;
      reset      = $urandom_range(0, 199) == 0;
      tick();
    end
    reset      = 1'b0;
    push_valid = 1'b0;
    data_ready = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_data_out_bfm.md
RV_DATA_OUT_BFM -- requirements
Module: rv_data_out_bfm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the data path.
REQ-002 SHALL have parameter DEPTH, default 16, a power of two of at least 2, giving the number of queued source words.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port data, output, DATA_WIDTH, the word currently offered to the sink.
REQ-006 SHALL have port data_valid, output, 1, meaning data holds a valid word.
REQ-007 SHALL have port data_ready, input, 1, the sink's accept signal; it may be combinational in the sink.
REQ-008 SHALL have port push_data, input, DATA_WIDTH, the host word to enqueue.
REQ-009 SHALL have port push_valid, input, 1, the host enqueue request.
REQ-010 SHALL have port push_ready, output, 1, meaning the queue can accept a word.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1, the number of queued words.
REQ-012 SHALL have port xfer_valid, output, 1, a one-cycle monitor pulse per completed transfer.
REQ-013 SHALL have port xfer_data, output, DATA_WIDTH, the word of the last completed transfer.
REQ-014 SHALL have port xfer_count, output, 32, the number of completed transfers.

Function
REQ-015 SHALL treat push_valid && push_ready at a rising edge as a push, and data_valid && data_ready at a rising edge as a transfer.
REQ-016 SHALL keep words in FIFO order and present the oldest word on data while data_valid=1.
REQ-017 SHALL drive data_valid = (level != 0) from registered state only, with no combinational path from data_ready to data_valid or data.
REQ-018 SHALL hold data_valid high and data stable until a transfer; a word SHALL NOT be withdrawn.
REQ-019 SHALL drive push_ready = (level != DEPTH) && !reset.
REQ-020 SHALL make a pushed word visible on data no earlier than the cycle after the push (1-cycle latency into an empty queue).
REQ-021 SHALL perform both operations when a push and a transfer occur in the same cycle: level unchanged, pointers both advance.
REQ-022 SHALL ignore push_valid when full; the word is neither stored nor overwritten.
REQ-023 SHALL ignore data_ready while data_valid=0.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; level SHALL distinguish full from empty.
REQ-025 SHALL, in the cycle after each transfer, assert xfer_valid for exactly one cycle, set xfer_data to the transferred word, and increment xfer_count by 1 (mod 2^32).
REQ-026 SHALL hold xfer_data between transfers.
REQ-027 SHALL handle back-to-back transfers (data_ready held high) at one word per cycle, with xfer_valid high on consecutive cycles.

Reset
REQ-028 SHALL, while reset=1, force data_valid=0, push_ready=0, level=0, xfer_valid=0, xfer_count=0, xfer_data=0, and data=0.
REQ-029 SHALL, on reset asserted mid-operation, discard all queued words and any in-flight monitor pulse at the next edge.
REQ-030 SHALL accept the first push in the first cycle after reset deasserts.

Structure
REQ-031 SHALL place DATA_WIDTH/DEPTH defaults and the level-width function in a shared package rv_bfm_pkg.
REQ-032 SHALL implement the storage as one sub-module rv_bfm_fifo (synchronous FIFO with push/pop, full/empty, level).
REQ-033 SHALL implement the monitor outputs in the top module, driven from the data/data_valid/data_ready handshake alone.

Verification
REQ-034 SHALL cover this scenario: reset held for 11 cycles with push_valid=1 -> push_ready=0 and data_valid=0 throughout, level=0 after release.
REQ-035 SHALL cover this scenario: push 0x00000001..0x00000005 with data_ready=0 -> level=5, data=0x00000001 held stable, data_valid=1.
REQ-036 SHALL cover this scenario: sink with random 0..31-cycle ready delays, drain 5 words -> xfer_data sequence 1,2,3,4,5 in order, xfer_count=5, one xfer_valid pulse each.
REQ-037 SHALL cover this scenario: fill 16 words, then push 0xDEADBEEF -> push_ready=0, word dropped; after 16 transfers xfer_count=16 and 0xDEADBEEF is never seen.
REQ-038 SHALL cover this scenario: data_ready=1 constant with simultaneous push/transfer each cycle for 100 cycles -> level constant, xfer_valid high every cycle, order preserved.
REQ-039 SHALL cover this scenario: reset asserted with level=7 -> next cycle level=0, data_valid=0, xfer_count=0.
